// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the multi-operand accumulator
//   op_e    : fold operation select, 3-bit encoding carried on op_i
//   state_e : accumulator FSM states
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OpAdd = 3'd0,
        OpMul = 3'd1,
        OpAnd = 3'd2,
        OpOr  = 3'd3,
        OpXor = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StAccum = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_unit.sv
// rtl/alu_op_unit.sv - combinational W-bit unsigned ALU with overflow flag
//   a, b : operands (unsigned, W bits)
//   op   : operation code (alu_pkg::op_e encoding; unknown codes act as ADD)
//   y    : result modulo 2^W
//   ovf  : ADD carry out / MUL nonzero upper half; never set for logic ops
module alu_op_unit
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [W-1:0]    y,
    output logic            ovf
);

    logic [W:0]     w_sum;
    logic [2*W-1:0] w_prod;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    always_comb begin
        // ADD is the default so that reserved op codes fall back to it.
        y   = w_sum[W-1:0];
        ovf = w_sum[W];
        case (op)
            OpMul: begin
                y   = w_prod[W-1:0];
                ovf = |w_prod[2*W-1:W];
            end
            OpAnd: begin
                y   = a & b;
                ovf = 1'b0;
            end
            OpOr: begin
                y   = a | b;
                ovf = 1'b0;
            end
            OpXor: begin
                y   = a ^ b;
                ovf = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_accum.sv
// rtl/alu_accum.sv - byte-serial multi-operand accumulator (add/mul/and/or/xor)
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i, data_i     : operand beat stream, MSB-first, accepted on valid_i & ready_o
//   ready_o             : high only while loading an operand
//   start_i, op_i, len_i: job request, sampled only in StIdle
//   busy_o, done_o      : job in progress / one-cycle completion pulse
//   result_o, overflow_o: accumulator and sticky overflow, held until next start
module alu_accum
    import alu_pkg::*;
#(
    parameter int datawidth_p = 8,
    parameter int opb_p       = 4,
    parameter int lenwidth_p  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic [datawidth_p-1:0]       data_i,
    output logic                         ready_o,
    input  logic                         start_i,
    input  logic [OP_W-1:0]              op_i,
    input  logic [lenwidth_p-1:0]        len_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [datawidth_p*opb_p-1:0] result_o,
    output logic                         overflow_o
);

    localparam int W      = datawidth_p * opb_p;
    localparam int BEAT_W = (opb_p > 1) ? $clog2(opb_p) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(opb_p - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [OP_W-1:0]       r_op;
    logic [lenwidth_p-1:0] r_len;
    logic [lenwidth_p-1:0] r_op_cnt;
    logic [lenwidth_p-1:0] w_op_cnt_next;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [BEAT_W-1:0]     w_pos;
    logic [W-1:0]          r_operand;
    logic [W-1:0]          r_acc;
    logic                  r_ovf;
    logic [W-1:0]          w_alu_y;
    logic                  w_alu_ovf;
    logic                  w_start_ok;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_last_op;
    logic                  w_first_op;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_done;

    alu_op_unit #(
        .W (W)
    ) u_op_unit (
        .a   (r_acc),
        .b   (r_operand),
        .op  (r_op),
        .y   (w_alu_y),
        .ovf (w_alu_ovf)
    );

    assign w_start_ok  = (r_state == StIdle) && start_i;
    assign w_beat      = (r_state == StLoad) && valid_i;
    assign w_last_beat = w_beat && (r_beat_cnt == LAST_BEAT);
    assign w_pos       = LAST_BEAT - r_beat_cnt;
    // The counter only ever reaches r_len, so the maximum length fits without wrap.
    assign w_op_cnt_next = r_op_cnt + 1'b1;
    assign w_last_op     = (w_op_cnt_next == r_len);
    assign w_first_op    = (r_op_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            StIdle: begin
                w_busy = 1'b0;
                if (start_i) begin
                    w_state_next = (len_i == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                w_ready = 1'b1;
                if (w_last_beat) begin
                    w_state_next = StAccum;
                end
            end
            StAccum: begin
                w_state_next = w_last_op ? StDone : StLoad;
            end
            StDone: begin
                w_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op       <= '0;
            r_len      <= '0;
            r_op_cnt   <= '0;
            r_beat_cnt <= '0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_op       <= op_i;
                r_len      <= len_i;
                r_op_cnt   <= '0;
                r_beat_cnt <= '0;
                r_operand  <= '0;
                r_acc      <= '0;
                r_ovf      <= 1'b0;
            end
            if (w_beat) begin
                // Beat n lands in byte lane opb_p-1-n so the first beat is the MSB.
                for (int k = 0; k < opb_p; k++) begin
                    if (w_pos == BEAT_W'(k)) begin
                        r_operand[k*datawidth_p +: datawidth_p] <= data_i;
                    end
                end
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
            if (r_state == StAccum) begin
                r_op_cnt <= w_op_cnt_next;
                if (w_first_op) begin
                    // The first operand seeds the accumulator; nothing to fold yet.
                    r_acc <= r_operand;
                end else begin
                    r_acc <= w_alu_y;
                    if (w_alu_ovf) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign ready_o    = w_ready;
    assign busy_o     = w_busy;
    assign done_o     = w_done;
    assign result_o   = r_acc;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_accum.sv
// tb/tb_alu_accum.sv - self-checking bench for alu_accum
module tb_alu_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        start;
    logic [2:0]  op;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    always #5 clk = ~clk;

    alu_accum #(
        .datawidth_p (8),
        .opb_p       (4),
        .lenwidth_p  (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .data_i     (data),
        .ready_o    (ready),
        .start_i    (start),
        .op_i       (op),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .overflow_o (ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        int          n;
        logic [31:0] v[3];
        logic [31:0] res;
        logic        ovf;
        int          gap;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] job_ops[$];
    int          poke_beat;
    bit          poke_done;
    bit          j_tmo;
    logic [31:0] j_res;
    logic        j_ovf;
    int          j_lat;

    task automatic set_vec(input int idx, input logic [2:0] o, input int n,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] r, input logic f, input int g);
        tbl[idx].op   = o;
        tbl[idx].n    = n;
        tbl[idx].v[0] = a;
        tbl[idx].v[1] = b;
        tbl[idx].v[2] = c;
        tbl[idx].res  = r;
        tbl[idx].ovf  = f;
        tbl[idx].gap  = g;
    endtask

    // Reference: fold the operand list with unbounded arithmetic, then reduce mod 2^32.
    function automatic logic [32:0] model(input logic [2:0] m_op);
        logic [63:0] acc;
        logic [63:0] b;
        logic [63:0] full;
        logic        mo;
        mo = 1'b0;
        if (job_ops.size() == 0) return 33'd0;
        acc = {32'd0, job_ops[0]};
        for (int i = 1; i < job_ops.size(); i++) begin
            b = {32'd0, job_ops[i]};
            case (m_op)
                3'd1:    full = acc * b;
                3'd2:    full = acc & b;
                3'd3:    full = acc | b;
                3'd4:    full = acc ^ b;
                default: full = acc + b;
            endcase
            if (full > 64'hFFFF_FFFF) mo = 1'b1;
            acc = full & 64'hFFFF_FFFF;
        end
        return {mo, acc[31:0]};
    endfunction

    task automatic feed_beat(input logic [7:0] d);
        int guard;
        valid = 1'b1;
        data  = d;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) j_tmo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_job(input logic [2:0] jop, input int gap_pct, input string name);
        int n;
        int beat_idx;
        n        = job_ops.size();
        beat_idx = 0;
        j_tmo    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = jop;
        len   = 16'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        len   = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (int'($urandom_range(0, 99)) < gap_pct) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                if (beat_idx == poke_beat) begin
                    start = 1'b1;
                    op    = 3'd1;
                    len   = 16'd9;
                end
                feed_beat(job_ops[i][31-8*k -: 8]);
                beat_idx++;
            end
        end
        j_lat = 1;
        while (!done && j_lat < 20) begin
            @(negedge clk);
            j_lat++;
        end
        j_res = result;
        j_ovf = ovf;
        if (poke_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        logic [32:0] exp;
        logic [2:0]  rop;
        int          rn;
        rst = 1'b1; valid = 1'b0; data = '0; start = 1'b0; op = '0; len = '0;
        poke_beat = -1; poke_done = 1'b0;

        set_vec(0,  3'd0, 2, 32'h1,         32'h2,         32'h0,         32'h3,         1'b0, 0);
        set_vec(1,  3'd0, 2, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b1, 0);
        set_vec(2,  3'd1, 3, 32'h2,         32'h3,         32'h4,         32'h18,        1'b0, 0);
        set_vec(3,  3'd1, 2, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h0,         1'b1, 0);
        set_vec(4,  3'd4, 2, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0,         32'h0F0F_F0F0, 1'b0, 40);
        set_vec(5,  3'd2, 3, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hF000_F000, 1'b0, 20);
        set_vec(6,  3'd3, 2, 32'h1234_0000, 32'h0000_5678, 32'h0,         32'h1234_5678, 1'b0, 0);
        set_vec(7,  3'd0, 3, 32'hFFFF_FFFF, 32'h1,         32'h5,         32'h5,         1'b1, 0);
        set_vec(8,  3'd7, 2, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h0,         1'b1, 0);
        set_vec(9,  3'd5, 2, 32'h10,        32'h20,        32'h0,         32'h30,        1'b0, 0);
        set_vec(10, 3'd0, 1, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        set_vec(11, 3'd1, 1, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("rst_ready",  {63'd0, ready},  64'd0);
        check("rst_busy",   {63'd0, busy},   64'd0);
        check("rst_done",   {63'd0, done},   64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_ovf",    {63'd0, ovf},    64'd0);
        rst = 1'b0;

        // Table-driven jobs.
        for (int i = 0; i < 12; i++) begin
            job_ops.delete();
            for (int j = 0; j < tbl[i].n; j++) job_ops.push_back(tbl[i].v[j]);
            poke_done = (i == 0);
            run_job(tbl[i].op, tbl[i].gap, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tmo", i),  {63'd0, j_tmo}, 64'd0);
            check($sformatf("vec%0d_lat", i),  64'(j_lat),     64'd2);
            check($sformatf("vec%0d_res", i),  {32'd0, j_res}, {32'd0, tbl[i].res});
            check($sformatf("vec%0d_ovf", i),  {63'd0, j_ovf}, {63'd0, tbl[i].ovf});
            check($sformatf("vec%0d_hold", i), {32'd0, result}, {32'd0, tbl[i].res});
        end
        poke_done = 1'b0;

        // len=0: straight to done, no beat taken even with valid held high.
        @(negedge clk);
        start = 1'b1; op = 3'd0; len = 16'd0; valid = 1'b1; data = 8'hAA;
        check("len0_ready_start", {63'd0, ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("len0_done",   {63'd0, done},   64'd1);
        check("len0_ready",  {63'd0, ready},  64'd0);
        check("len0_result", {32'd0, result}, 64'd0);
        check("len0_ovf",    {63'd0, ovf},    64'd0);
        @(negedge clk);
        check("len0_after_done",  {63'd0, done},  64'd0);
        check("len0_after_busy",  {63'd0, busy},  64'd0);
        check("len0_after_ready", {63'd0, ready}, 64'd0);
        valid = 1'b0;

        job_ops.delete();
        job_ops.push_back(32'h1);
        job_ops.push_back(32'h2);
        run_job(3'd0, 0, "post_len0");
        check("post_len0_res", {32'd0, j_res}, 64'h3);
        check("post_len0_lat", 64'(j_lat), 64'd2);

        // start_i pulsed while loading must not disturb the job.
        job_ops.delete();
        job_ops.push_back(32'h5);
        job_ops.push_back(32'h7);
        poke_beat = 5;
        run_job(3'd0, 0, "poke");
        poke_beat = -1;
        check("poke_res", {32'd0, j_res}, 64'hC);
        check("poke_ovf", {63'd0, j_ovf}, 64'd0);
        check("poke_lat", 64'(j_lat), 64'd2);

        // Reset in the middle of the second operand's load.
        j_tmo = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; len = 16'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) feed_beat(8'hFF);
        feed_beat(8'h12);
        feed_beat(8'h34);
        check("mid_tmo",          {63'd0, j_tmo},  64'd0);
        check("mid_partial_busy", {63'd0, busy},   64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready",  {63'd0, ready},  64'd0);
        check("mid_rst_busy",   {63'd0, busy},   64'd0);
        check("mid_rst_done",   {63'd0, done},   64'd0);
        check("mid_rst_result", {32'd0, result}, 64'd0);
        check("mid_rst_ovf",    {63'd0, ovf},    64'd0);
        @(negedge clk);
        check("mid_rst_stays_idle", {63'd0, busy}, 64'd0);

        job_ops.delete();
        job_ops.push_back(32'h1);
        job_ops.push_back(32'h2);
        run_job(3'd0, 0, "post_rst");
        check("post_rst_res", {32'd0, j_res}, 64'h3);
        check("post_rst_ovf", {63'd0, j_ovf}, 64'd0);

        // Randomized jobs against the reference model.
        for (int r = 0; r < 25; r++) begin
            rop = 3'($urandom_range(0, 7));
            rn  = $urandom_range(1, 4);
            job_ops.delete();
            for (int j = 0; j < rn; j++) begin
                if ($urandom_range(0, 1) == 1) job_ops.push_back(32'($urandom_range(0, 300)));
                else                           job_ops.push_back($urandom);
            end
            exp = model(rop);
            run_job(rop, 30, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_tmo", r), {63'd0, j_tmo}, 64'd0);
            check($sformatf("rnd%0d_lat", r), 64'(j_lat),     64'd2);
            check($sformatf("rnd%0d_res", r), {32'd0, j_res}, {32'd0, exp[31:0]});
            check($sformatf("rnd%0d_ovf", r), {63'd0, j_ovf}, {63'd0, exp[32]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
